// File: rtl/sr595_frame_driver_if.sv
// ============================================================================
// Module      : sr595_frame_driver_if
// Description : Handshake and pin bundle between system logic and the driver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sr595_frame_driver_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] DIN;
  logic              LOAD;
  logic              READY;
  logic              CLEAR;
  logic              OE_REQ;
  logic              BUSY;
  logic              DONE;
  logic              DS;
  logic              SHCP;
  logic              STCP;
  logic              MR_bar;
  logic              OE_bar;

  modport master (
    output DIN, LOAD, CLEAR, OE_REQ,
    input  READY, BUSY, DONE, DS, SHCP, STCP, MR_bar, OE_bar
  );

  modport slave (
    input  DIN, LOAD, CLEAR, OE_REQ,
    output READY, BUSY, DONE, DS, SHCP, STCP, MR_bar, OE_bar
  );
endinterface

`default_nettype wire

// File: rtl/sr595_frame_driver.sv
// ============================================================================
// Module      : sr595_frame_driver
// Description : Serialises words LSB first onto a 595-style SIPO register and
//               latches them; optional clear sequencing under SR_CLEAR_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sr595_frame_driver #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  sr595_frame_driver_if.slave  bus
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] C_DIV_M1  = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] C_BITS_M1 = BW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SH_LO = 3'd1;
  localparam logic [2:0] S_SH_HI = 3'd2;
  localparam logic [2:0] S_LT_HI = 3'd3;
  localparam logic [2:0] S_LT_LO = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
`ifdef SR_CLEAR_EN
  localparam logic [2:0] S_CL_LO = 3'd6;
  localparam logic [2:0] S_CL_LT = 3'd7;
`endif

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bits_q, bits_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              ds_q, ds_d;
  logic              shcp_q, shcp_d;
  logic              stcp_q, stcp_d;
  logic              mr_q, mr_d;
  logic              oe_q;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              w_tick;
  logic              w_clr_req;

`ifdef SR_CLEAR_EN
  logic pend_q, pend_d;
  assign w_clr_req = bus.CLEAR;
`else
  logic w_unused_clear;
  assign w_unused_clear = bus.CLEAR;
  assign w_clr_req      = 1'b0;
`endif

  assign w_tick = (cnt_q == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= C_DIV_M1;
      bits_q  <= '0;
      buf_q   <= '0;
      ds_q    <= 1'b0;
      shcp_q  <= 1'b0;
      stcp_q  <= 1'b0;
      mr_q    <= 1'b1;
      oe_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SR_CLEAR_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      buf_q   <= buf_d;
      ds_q    <= ds_d;
      shcp_q  <= shcp_d;
      stcp_q  <= stcp_d;
      mr_q    <= mr_d;
      oe_q    <= ~bus.OE_REQ;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SR_CLEAR_EN
      pend_q  <= pend_d;
`endif
    end
  end

  // Next state; DS and the shift buffer only move when SH_LO is entered.
  always_comb begin
    state_d = state_q;
    bits_d  = bits_q;
    buf_d   = buf_q;
    ds_d    = ds_q;
`ifdef SR_CLEAR_EN
    pend_d  = pend_q;
    if (bus.CLEAR && (state_q == S_SH_LO || state_q == S_SH_HI ||
                      state_q == S_LT_HI || state_q == S_LT_LO))
      pend_d = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        if (ready_q) begin
`ifdef SR_CLEAR_EN
          if (w_clr_req) state_d = S_CL_LO;
`endif
          if (bus.LOAD && !w_clr_req) begin
            state_d = S_SH_LO;
            ds_d    = bus.DIN[0];
            buf_d   = bus.DIN >> 1;
            bits_d  = C_BITS_M1;
          end
        end
      end
      S_SH_LO: if (w_tick) state_d = S_SH_HI;
      S_SH_HI: begin
        if (w_tick) begin
          if (bits_q != '0) begin
            state_d = S_SH_LO;
            ds_d    = buf_q[0];
            buf_d   = buf_q >> 1;
            bits_d  = bits_q - 1'b1;
          end else begin
            state_d = S_LT_HI;
          end
        end
      end
      S_LT_HI: if (w_tick) state_d = S_LT_LO;
      S_LT_LO: if (w_tick) state_d = S_FIN;
      S_FIN: begin
        state_d = S_IDLE;
`ifdef SR_CLEAR_EN
        if (pend_q || bus.CLEAR) begin
          state_d = S_CL_LO;
          pend_d  = 1'b0;
        end
`endif
      end
`ifdef SR_CLEAR_EN
      S_CL_LO: if (w_tick) state_d = S_CL_LT;
      S_CL_LT: if (w_tick) state_d = S_FIN;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Every timed state exits to a different state, so a state change reloads.
  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (state_d != state_q || state_q == S_IDLE)
      cnt_d = C_DIV_M1;
  end

  always_comb begin
    shcp_d  = (state_d == S_SH_HI);
    stcp_d  = (state_d == S_LT_HI);
    mr_d    = 1'b1;
`ifdef SR_CLEAR_EN
    stcp_d  = stcp_d || (state_d == S_CL_LT);
    mr_d    = (state_d != S_CL_LO);
`endif
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d  = (state_d == S_FIN);
  end

  assign bus.DS     = ds_q;
  assign bus.SHCP   = shcp_q;
  assign bus.STCP   = stcp_q;
  assign bus.MR_bar = mr_q;
  assign bus.OE_bar = oe_q;
  assign bus.READY  = ready_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;

endmodule

`default_nettype wire
